// File: rtl/multicycle_alu_unit_pkg.sv
// alu_pkg: shared decode, multiply/divide and FSM types for the execute-stage ALU
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_ctl_t;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef struct packed {
        logic     is_m;
        alu_ctl_t ctl;
        md_op_t   md;
    } dec_t;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;
endpackage

// File: rtl/multicycle_alu_unit_if.sv
// multicycle_alu_unit_if: operation request and result handshake bundle
interface multicycle_alu_unit_if #(parameter int XLEN = 32);
    logic            in_valid, in_ready, op5, funct7_5, funct7_0;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a, src_b, result;
    logic            out_valid, out_ready, zero, lt, ltu;
    modport master (
        output in_valid, op5, alu_op, funct3, funct7_5, funct7_0, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, lt, ltu
    );
    modport slave (
        input  in_valid, op5, alu_op, funct3, funct7_5, funct7_0, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, lt, ltu
    );
endinterface

// File: rtl/multicycle_alu_unit_mul_div_iter.sv
// mul_div_iter: XLEN-step shift-add multiplier / restoring divider on operand magnitudes
module mul_div_iter
    import alu_pkg::*;
#(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  md_op_t          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);
    logic [XLEN-1:0]   hi, lo, m, hi_n, lo_n, ma, mb;
    logic [XLEN:0]     sum, r_sh, diff;
    logic [2*XLEN-1:0] prod;
    logic [CW-1:0]     cnt;
    logic              busy, neg_q, neg_r, sa, sb, ge;
    md_op_t            op_q;
    assign sa = a[XLEN-1] & (op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM);
    assign sb = b[XLEN-1] & (op == MD_MULH || op == MD_DIV || op == MD_REM);
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;
    // hi:lo is the running product for multiply, remainder:quotient for divide
    always_comb begin
        sum  = {1'b0, hi} + {1'b0, lo[0] ? m : '0};
        r_sh = {hi, lo[XLEN-1]};
        diff = r_sh - {1'b0, m};
        ge   = ~diff[XLEN];
        hi_n = op_q[2] ? (ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0]) : sum[XLEN:1];
        lo_n = op_q[2] ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
        prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        res  = op_q == MD_MUL ? prod[XLEN-1:0] :
               !op_q[2]       ? prod[2*XLEN-1:XLEN] :
               op_q[1]        ? (neg_r ? -hi_n : hi_n) : (neg_q ? -lo_n : lo_n);
        done = busy && cnt == CW'(XLEN - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            op_q  <= MD_MUL;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            hi    <= '0;
            lo    <= op[2] ? ma : mb;
            m     <= op[2] ? mb : ma;
            neg_q <= (sa ^ sb) & (~op[2] | (|b));
            neg_r <= sa;
            op_q  <= op;
        end else if (busy) begin
            hi   <= hi_n;
            lo   <= lo_n;
            cnt  <= cnt + 1'b1;
            busy <= ~done;
        end
    end
endmodule

// File: rtl/multicycle_alu_unit.sv
// multicycle_alu_unit: RV32I execute ALU with built-in decode and iterative RV32M,
// registered result returned over a valid/ready handshake
module multicycle_alu_unit
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_alu_unit_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    function automatic dec_t decode(input logic [1:0] aop, input logic [2:0] f3,
                                    input logic op5, input logic f75, input logic f70);
        dec_t d;
        d.is_m = aop == ALUOP_ARITH && op5 && f70 && ENABLE_M;
        d.md   = md_op_t'(f3);
        d.ctl  = aop == ALUOP_BR ? ALU_SUB : ALU_ADD;
        if (aop == ALUOP_ARITH)
            case (f3)
                3'b000:  d.ctl = (op5 && f75) ? ALU_SUB : ALU_ADD;
                3'b001:  d.ctl = ALU_SLL;
                3'b010:  d.ctl = ALU_SLT;
                3'b011:  d.ctl = ALU_SLTU;
                3'b100:  d.ctl = ALU_XOR;
                3'b101:  d.ctl = f75 ? ALU_SRA : ALU_SRL;
                3'b110:  d.ctl = ALU_OR;
                default: d.ctl = ALU_AND;
            endcase
        return d;
    endfunction
    state_t          state, state_n;
    dec_t            dec;
    logic            accept, md_done, lt_s, ltu_s;
    logic [XLEN-1:0] a, b, sra_v, base, md_res;
    logic [SW-1:0]   sh;
    assign a      = bus.src_a;
    assign b      = bus.src_b;
    assign dec    = decode(bus.alu_op, bus.funct3, bus.op5, bus.funct7_5, bus.funct7_0);
    assign accept = bus.in_valid & bus.in_ready;
    assign sh     = b[SW-1:0];
    assign lt_s   = $signed(a) < $signed(b);
    assign ltu_s  = a < b;
    // kept apart so the arithmetic shift is not forced unsigned by the select chain
    assign sra_v  = $signed(a) >>> sh;
    always_comb
        base = dec.ctl == ALU_SUB  ? a - b :
               dec.ctl == ALU_SLL  ? a << sh :
               dec.ctl == ALU_SLT  ? {{(XLEN-1){1'b0}}, lt_s} :
               dec.ctl == ALU_SLTU ? {{(XLEN-1){1'b0}}, ltu_s} :
               dec.ctl == ALU_XOR  ? a ^ b :
               dec.ctl == ALU_SRL  ? a >> sh :
               dec.ctl == ALU_SRA  ? sra_v :
               dec.ctl == ALU_OR   ? a | b :
               dec.ctl == ALU_AND  ? a & b : a + b;
    mul_div_iter #(.XLEN(XLEN)) u_md (
        .clk  (clk),
        .rst  (rst),
        .start(accept & dec.is_m),
        .op   (dec.md),
        .a    (a),
        .b    (b),
        .done (md_done),
        .res  (md_res)
    );
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb
        state_n = state == IDLE ? (accept ? (dec.is_m ? CALC : DONE) : IDLE) :
                  state == CALC ? (md_done ? DONE : CALC) :
                  bus.out_ready ? IDLE : DONE;
    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result <= '0;
            bus.zero   <= 1'b0;
            bus.lt     <= 1'b0;
            bus.ltu    <= 1'b0;
        end else if (accept) begin
            bus.lt  <= lt_s;
            bus.ltu <= ltu_s;
            if (!dec.is_m) begin
                bus.result <= base;
                bus.zero   <= base == '0;
            end
        end else if (state == CALC && md_done) begin
            bus.result <= md_res;
            bus.zero   <= md_res == '0;
        end
    end
endmodule

// File: tb/tb_multicycle_alu_unit.sv
// tb_multicycle_alu_unit: scoreboard bench for decode, base ops, M ops, corners, backpressure, reset
module tb_multicycle_alu_unit;
    typedef struct {
        logic [31:0] res;
        logic        z, lt, ltu;
        int          lat;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1;
    int   n_vec = 0, n_bad = 0, idx = 0;
    exp_t sb[$];
    multicycle_alu_unit_if #(.XLEN(32)) bus ();
    multicycle_alu_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [1:0] aop, input logic op5, input logic [2:0] f3,
                                          input logic f75, input logic f70,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [31:0]        r;
        logic               ovf;
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        if (aop == 2'b01) return a - b;
        if (aop != 2'b10) return a + b;
        if (op5 && f70) begin
            case (f3)
                3'd0: r = a * b;
                3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
                3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
                3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
                3'd4: if (b == 0) r = '1; else if (ovf) r = a; else r = $signed(a) / $signed(b);
                3'd5: if (b == 0) r = '1; else r = a / b;
                3'd6: if (b == 0) r = a; else if (ovf) r = '0; else r = $signed(a) % $signed(b);
                default: if (b == 0) r = a; else r = a % b;
            endcase
            return r;
        end
        case (f3)
            3'd0: r = (op5 && f75) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, $signed(a) < $signed(b)};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: if (f75) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction
    task automatic drive_op(input logic [1:0] aop, input logic op5, input logic [2:0] f3,
                            input logic f75, input logic f70, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   k = 0;
        do begin @(negedge clk); k++; end while (!bus.in_ready && k < 60);
        check($sformatf("rdy#%0d", idx), {31'b0, bus.in_ready}, 32'd1);
        e.res = model(aop, op5, f3, f75, f70, a, b);
        e.z   = e.res == 0;
        e.lt  = $signed(a) < $signed(b);
        e.ltu = a < b;
        e.lat = (aop == 2'b10 && op5 && f70) ? 33 : 1;
        sb.push_back(e);
        bus.alu_op = aop; bus.op5 = op5; bus.funct3 = f3; bus.funct7_5 = f75; bus.funct7_0 = f70;
        bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask
    task automatic collect(input int hold);
        exp_t e;
        int   lat = 1;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check($sformatf("lat#%0d", idx), lat, e.lat);
        check($sformatf("res#%0d", idx), bus.result, e.res);
        check($sformatf("zero#%0d", idx), {31'b0, bus.zero}, {31'b0, e.z});
        check($sformatf("lt#%0d", idx), {31'b0, bus.lt}, {31'b0, e.lt});
        check($sformatf("ltu#%0d", idx), {31'b0, bus.ltu}, {31'b0, e.ltu});
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            // a request arriving while the result waits must be ignored
            bus.in_valid = 1'b1; bus.alu_op = 2'b00; bus.src_a = 32'h1111; bus.src_b = 32'h2222;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check($sformatf("hold_vld#%0d", idx), {31'b0, bus.out_valid}, 32'd1);
                check($sformatf("hold_res#%0d", idx), bus.result, e.res);
                check($sformatf("hold_rdy#%0d", idx), {31'b0, bus.in_ready}, 32'd0);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        idx++;
    endtask
    task automatic run(input logic [1:0] aop, input logic op5, input logic [2:0] f3,
                       input logic f75, input logic f70, input logic [31:0] a, input logic [31:0] b);
        drive_op(aop, op5, f3, f75, f70, a, b);
        collect(0);
    endtask
    initial begin
        logic [1:0]  ao;
        logic [2:0]  f3;
        logic        o5, f75, f70;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.alu_op = 2'b00; bus.op5 = 1'b0;
        bus.funct3 = 3'b0; bus.funct7_5 = 1'b0; bus.funct7_0 = 1'b0; bus.src_a = '0; bus.src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", {31'b0, bus.out_valid}, 32'd0);
        check("rst_res", bus.result, 32'd0);
        check("rst_flags", {29'b0, bus.zero, bus.lt, bus.ltu}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("rst_rdy", {31'b0, bus.in_ready}, 32'd1);
        run(2'b00, 0, 3'd0, 0, 0, 32'd5, 32'd7);
        run(2'b01, 0, 3'd0, 0, 0, 32'h8000_0000, 32'h8000_0000);
        run(2'b01, 0, 3'd0, 0, 0, 32'hFFFF_FFFF, 32'd1);
        run(2'b10, 0, 3'd0, 1, 0, 32'd3, 32'd4);
        run(2'b10, 1, 3'd0, 1, 0, 32'd3, 32'd4);
        run(2'b10, 1, 3'd5, 1, 0, 32'h8000_0000, 32'd4);
        run(2'b10, 0, 3'd5, 1, 0, 32'h8000_0000, 32'd4);
        run(2'b10, 1, 3'd5, 0, 0, 32'h8000_0000, 32'd4);
        run(2'b10, 1, 3'd1, 0, 0, 32'h0000_0013, 32'd31);
        run(2'b10, 1, 3'd2, 0, 0, 32'hFFFF_FFF0, 32'd2);
        run(2'b10, 0, 3'd3, 0, 0, 32'hFFFF_FFF0, 32'd2);
        run(2'b10, 1, 3'd4, 0, 0, 32'hF0F0_1234, 32'h0FF0_4321);
        run(2'b10, 1, 3'd6, 0, 0, 32'hF000_0001, 32'h0000_0F10);
        run(2'b10, 1, 3'd7, 0, 0, 32'hF0F0_FFFF, 32'h0FFF_00F0);
        run(2'b11, 1, 3'd4, 1, 1, 32'd100, 32'hFFFF_FFFF);
        run(2'b10, 1, 3'd1, 0, 1, 32'hFFFF_FFFE, 32'd3);
        run(2'b10, 1, 3'd3, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b10, 1, 3'd0, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0);
        run(2'b10, 1, 3'd2, 0, 1, 32'hFFFF_FFFF, 32'd2);
        run(2'b10, 1, 3'd4, 0, 1, 32'd7, 32'd0);
        run(2'b10, 1, 3'd6, 0, 1, 32'd7, 32'd0);
        run(2'b10, 1, 3'd4, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b10, 1, 3'd6, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b10, 1, 3'd6, 0, 1, 32'hFFFF_FFF9, 32'd2);
        run(2'b10, 1, 3'd4, 0, 1, 32'hFFFF_FFF9, 32'd0);
        run(2'b10, 1, 3'd4, 0, 1, 32'hFFFF_FFEC, 32'd3);
        run(2'b10, 1, 3'd5, 0, 1, 32'd100, 32'd7);
        run(2'b10, 1, 3'd7, 0, 1, 32'd100, 32'd7);
        drive_op(2'b00, 0, 3'd0, 0, 0, 32'h0000_0040, 32'h0000_0002);
        collect(5);
        drive_op(2'b10, 1, 3'd3, 0, 1, 32'hFFFF_FFFF, 32'h0000_0003);
        collect(5);
        drive_op(2'b10, 1, 3'd0, 0, 1, 32'hFFFF_FFFB, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_vld", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_rdy", {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_res", bus.result, 32'd0);
        check("mid_rst_lt", {31'b0, bus.lt}, 32'd0);
        @(negedge clk) rst = 1'b0;
        sb.delete();
        run(2'b00, 0, 3'd0, 0, 0, 32'hFFFF_FFFF, 32'd1);
        run(2'b10, 1, 3'd1, 0, 1, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 24; i++) begin
            ao  = 2'($urandom_range(0, 3));
            o5  = 1'($urandom);
            f3  = 3'($urandom);
            f75 = 1'($urandom);
            f70 = 1'($urandom);
            run(ao, o5, f3, f75, f70, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
